// File: rtl/hls_kernel_launcher.sv
// AXI-Lite master that writes three kernel arguments and ap_start into an HLS
// control map, then polls ap_done until completion, slave error or poll timeout.
module hls_kernel_launcher #(
    parameter int ADDR_W   = 12,
    parameter int POLL_GAP = 16,
    parameter int TIMEOUT  = 2**20
) (
    input  logic              CLK_IN_250,
    input  logic              AXI_RESET_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_arg0,
    input  logic [31:0]       cmd_arg1,
    input  logic [31:0]       cmd_arg2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [19:0]       rsp_polls,
    output logic              busy,
    output logic [ADDR_W-1:0] M_AXI_LITE_awaddr,
    output logic [2:0]        M_AXI_LITE_awprot,
    output logic              M_AXI_LITE_awvalid,
    input  logic              M_AXI_LITE_awready,
    output logic [31:0]       M_AXI_LITE_wdata,
    output logic [3:0]        M_AXI_LITE_wstrb,
    output logic              M_AXI_LITE_wvalid,
    input  logic              M_AXI_LITE_wready,
    input  logic [1:0]        M_AXI_LITE_bresp,
    input  logic              M_AXI_LITE_bvalid,
    output logic              M_AXI_LITE_bready,
    output logic [ADDR_W-1:0] M_AXI_LITE_araddr,
    output logic [2:0]        M_AXI_LITE_arprot,
    output logic              M_AXI_LITE_arvalid,
    input  logic              M_AXI_LITE_arready,
    input  logic [31:0]       M_AXI_LITE_rdata,
    input  logic [1:0]        M_AXI_LITE_rresp,
    input  logic              M_AXI_LITE_rvalid,
    output logic              M_AXI_LITE_rready
);
    // state | meaning: IDLE wait cmd | WR issue aw/w | WR_B await b | RD issue ar
    //                  RD_R await r | GAP spacing between polls | RSP hold result
    typedef enum logic [2:0] {IDLE, WR, WR_B, RD, RD_R, GAP, RSP} state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_SLVERR  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    state_t            state_q;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       arg0_q, arg1_q, arg2_q;
    logic [20:0]       polls_q, polls_d;
    logic [31:0]       gap_q;
    logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q;
    logic              cmd_ready_q, rsp_valid_q;
    logic [1:0]        status_q;
    logic              aw_done, w_done;
    logic              unused_rdata;

    function automatic logic [ADDR_W-1:0] wr_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    wr_addr = ADDR_W'(8'h10);
            2'd1:    wr_addr = ADDR_W'(8'h18);
            2'd2:    wr_addr = ADDR_W'(8'h20);
            default: wr_addr = '0;
        endcase
    endfunction

    function automatic logic [31:0] wr_data(input logic [1:0] idx, input logic [31:0] a1,
                                            input logic [31:0] a2);
        case (idx)
            2'd1:    wr_data = a1;
            2'd2:    wr_data = a2;
            default: wr_data = 32'h0000_0001;
        endcase
    endfunction

    assign idx_d   = idx_q + 2'd1;
    assign polls_d = (polls_q == '1) ? polls_q : polls_q + 21'd1;
    // A channel whose handshake already happened counts as done
    assign aw_done = !awvalid_q || M_AXI_LITE_awready;
    assign w_done  = !wvalid_q || M_AXI_LITE_wready;
    assign unused_rdata = ^{M_AXI_LITE_rdata[31:2], M_AXI_LITE_rdata[0]};

    always_ff @(posedge CLK_IN_250) begin
        if (!AXI_RESET_N) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            arg0_q      <= '0;
            arg1_q      <= '0;
            arg2_q      <= '0;
            polls_q     <= '0;
            gap_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            status_q    <= ST_OK;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    arg0_q      <= cmd_arg0;
                    arg1_q      <= cmd_arg1;
                    arg2_q      <= cmd_arg2;
                    idx_q       <= '0;
                    polls_q     <= '0;
                    awaddr_q    <= wr_addr(2'd0);
                    wdata_q     <= cmd_arg0;
                    awvalid_q   <= 1'b1;
                    wvalid_q    <= 1'b1;
                    cmd_ready_q <= 1'b0;
                    state_q     <= WR;
                end
                WR: begin
                    if (M_AXI_LITE_awready) awvalid_q <= 1'b0;
                    if (M_AXI_LITE_wready)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_B;
                    end
                end
                WR_B: if (M_AXI_LITE_bvalid) begin
                    bready_q <= 1'b0;
                    if (M_AXI_LITE_bresp != 2'b00) begin
                        status_q    <= ST_SLVERR;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end else if (idx_q == 2'd3) begin
                        arvalid_q <= 1'b1;
                        state_q   <= RD;
                    end else begin
                        idx_q     <= idx_d;
                        awaddr_q  <= wr_addr(idx_d);
                        wdata_q   <= wr_data(idx_d, arg1_q, arg2_q);
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= WR;
                    end
                end
                RD: if (M_AXI_LITE_arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= RD_R;
                end
                RD_R: if (M_AXI_LITE_rvalid) begin
                    rready_q <= 1'b0;
                    polls_q  <= polls_d;
                    if (M_AXI_LITE_rresp != 2'b00) begin
                        status_q    <= ST_SLVERR;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end else if (M_AXI_LITE_rdata[1]) begin
                        status_q    <= ST_OK;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end else if (32'(polls_d) == 32'(TIMEOUT)) begin
                        status_q    <= ST_TIMEOUT;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end else begin
                        gap_q   <= 32'(POLL_GAP - 1);
                        state_q <= GAP;
                    end
                end
                GAP: if (gap_q == '0) begin
                    arvalid_q <= 1'b1;
                    state_q   <= RD;
                end else begin
                    gap_q <= gap_q - 32'd1;
                end
                RSP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready          = cmd_ready_q;
    assign busy               = !cmd_ready_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_status         = status_q;
    assign rsp_polls          = polls_q[20] ? '1 : polls_q[19:0];
    assign M_AXI_LITE_awaddr  = awaddr_q;
    assign M_AXI_LITE_awprot  = 3'b000;
    assign M_AXI_LITE_awvalid = awvalid_q;
    assign M_AXI_LITE_wdata   = wdata_q;
    assign M_AXI_LITE_wstrb   = 4'hF;
    assign M_AXI_LITE_wvalid  = wvalid_q;
    assign M_AXI_LITE_bready  = bready_q;
    assign M_AXI_LITE_araddr  = '0;
    assign M_AXI_LITE_arprot  = 3'b000;
    assign M_AXI_LITE_arvalid = arvalid_q;
    assign M_AXI_LITE_rready  = rready_q;
endmodule

// File: tb/tb_hls_kernel_launcher.sv
// Directed bench for hls_kernel_launcher: vector table of launches against an
// AXI-Lite slave model, plus reset-mid-op and response-stall sequences.
module tb_hls_kernel_launcher;
    localparam int ADDR_W   = 12;
    localparam int POLL_GAP = 16;
    localparam int TIMEOUT  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [31:0] cmd_arg0, cmd_arg1, cmd_arg2;
    logic [1:0]  rsp_status;
    logic [19:0] rsp_polls;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    hls_kernel_launcher #(.ADDR_W(ADDR_W), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) dut (
        .CLK_IN_250(clk), .AXI_RESET_N(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1), .cmd_arg2(cmd_arg2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_polls(rsp_polls), .busy(busy),
        .M_AXI_LITE_awaddr(awaddr), .M_AXI_LITE_awprot(awprot),
        .M_AXI_LITE_awvalid(awvalid), .M_AXI_LITE_awready(awready),
        .M_AXI_LITE_wdata(wdata), .M_AXI_LITE_wstrb(wstrb),
        .M_AXI_LITE_wvalid(wvalid), .M_AXI_LITE_wready(wready),
        .M_AXI_LITE_bresp(bresp), .M_AXI_LITE_bvalid(bvalid), .M_AXI_LITE_bready(bready),
        .M_AXI_LITE_araddr(araddr), .M_AXI_LITE_arprot(arprot),
        .M_AXI_LITE_arvalid(arvalid), .M_AXI_LITE_arready(arready),
        .M_AXI_LITE_rdata(rdata), .M_AXI_LITE_rresp(rresp),
        .M_AXI_LITE_rvalid(rvalid), .M_AXI_LITE_rready(rready)
    );

    initial forever #2 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
        $fatal(1, "watchdog");
    end

    int n_chk = 0;
    int n_err = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // slave configuration (written by the main sequence only)
    bit bp_mode = 0;
    bit err_mode = 0;
    int done_at = 1;
    int rd_base = 0;

    // slave state (written by the slave process only)
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int rd_total = 0;
    int proto_err = 0;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, aw_arm, w_arm, ar_arm;
    bit b_pend, r_pend, b_err, r_done;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic [31:0] cur_a, cur_d;
    bit p_awv, p_wv, p_arv;
    logic [ADDR_W-1:0] p_awa, p_ara;
    logic [31:0] p_wd;

    function automatic int dly();
        return bp_mode ? int'($urandom_range(0, 7)) : 0;
    endfunction

    // AXI-Lite slave model: observes handshakes mid-cycle, drives just after the edge
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (p_awv && !(awvalid && awaddr == p_awa)) proto_err++;
                if (p_wv && !(wvalid && wdata == p_wd)) proto_err++;
                if (p_arv && !(arvalid && araddr == p_ara)) proto_err++;
                p_awv = awvalid && !awready; p_awa = awaddr;
                p_wv  = wvalid && !wready;   p_wd  = wdata;
                p_arv = arvalid && !arready; p_ara = araddr;
                aw_hs = awvalid && awready;
                w_hs  = wvalid && wready;
                b_hs  = bvalid && bready;
                ar_hs = arvalid && arready;
                r_hs  = rvalid && rready;
                if (aw_hs) begin cur_a = 32'(awaddr); aw_got = 1; end
                if (w_hs) begin cur_d = wdata; w_got = 1; end
                if (aw_got && w_got) begin
                    wa_q.push_back(cur_a);
                    wd_q.push_back(cur_d);
                    b_err = err_mode && (cur_a == 32'h18);
                    b_pend = 1; b_cnt = dly();
                    aw_got = 0; w_got = 0;
                end
                if (ar_hs) begin
                    rd_total++;
                    r_done = (rd_total - rd_base) >= done_at;
                    r_pend = 1; r_cnt = dly();
                end
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rresp = 0;
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
                aw_got = 0; w_got = 0; aw_arm = 0; w_arm = 0; ar_arm = 0;
                b_pend = 0; r_pend = 0; p_awv = 0; p_wv = 0; p_arv = 0;
            end else begin
                if (aw_hs) begin awready = 0; aw_arm = 0; end
                else if (awvalid && !awready) begin
                    if (!aw_arm) begin aw_arm = 1; aw_cnt = dly(); end
                    if (aw_cnt == 0) awready = 1; else aw_cnt--;
                end
                if (w_hs) begin wready = 0; w_arm = 0; end
                else if (wvalid && !wready) begin
                    if (!w_arm) begin w_arm = 1; w_cnt = dly(); end
                    if (w_cnt == 0) wready = 1; else w_cnt--;
                end
                if (ar_hs) begin arready = 0; ar_arm = 0; end
                else if (arvalid && !arready) begin
                    if (!ar_arm) begin ar_arm = 1; ar_cnt = dly(); end
                    if (ar_cnt == 0) arready = 1; else ar_cnt--;
                end
                if (b_hs) begin bvalid = 0; bresp = 0; end
                else if (b_pend && !bvalid) begin
                    if (b_cnt == 0) begin bvalid = 1; bresp = b_err ? 2'b10 : 2'b00; b_pend = 0; end
                    else b_cnt--;
                end
                if (r_hs) begin rvalid = 0; end
                else if (r_pend && !rvalid) begin
                    if (r_cnt == 0) begin
                        rvalid = 1; rresp = 2'b00;
                        rdata = r_done ? 32'h0000_0002 : 32'hFFFF_FFFD;
                        r_pend = 0;
                    end else r_cnt--;
                end
            end
        end
    end

    typedef struct {
        logic [31:0] a0, a1, a2;
        bit bp, err;
        int done_at;
        logic [1:0] st;
        int polls, nw, nr, lat;
    } vec_t;
    vec_t vecs[6];

    task automatic send_cmd(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] a2, input bit hold, output int acc);
        bit ok = 0;
        acc = 0;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_arg0 = a0; cmd_arg1 = a1; cmd_arg2 = a2;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; acc = cyc + 1; break; end
        end
        chk({tag, " accept"}, ok, 1);
        @(posedge clk); #1;
        if (!hold) cmd_valid = 0;
        @(negedge clk);
        chk({tag, " aw/w/busy after accept"}, {awvalid, wvalid, busy, cmd_ready}, 4'b1110);
    endtask

    task automatic wait_rsp(input string tag, input int acc, output int lat);
        bit seen = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rsp_valid) begin seen = 1; break; end
            @(negedge clk);
        end
        chk({tag, " rsp_valid seen"}, seen, 1);
        lat = cyc + 1 - acc;
    endtask

    task automatic run_launch(input string tag, input vec_t v);
        int acc, lat, wb, rb;
        logic [31:0] ea[4];
        logic [31:0] ed[4];
        ea[0] = 32'h10; ea[1] = 32'h18; ea[2] = 32'h20; ea[3] = 32'h00;
        ed[0] = v.a0; ed[1] = v.a1; ed[2] = v.a2; ed[3] = 32'h1;
        bp_mode = v.bp; err_mode = v.err; done_at = v.done_at;
        rd_base = rd_total; rb = rd_total; wb = wa_q.size();
        send_cmd(tag, v.a0, v.a1, v.a2, 0, acc);
        wait_rsp(tag, acc, lat);
        chk({tag, " status"}, rsp_status, v.st);
        chk({tag, " polls"}, rsp_polls, v.polls);
        if (v.lat != 0) chk({tag, " latency"}, lat, v.lat);
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        repeat (6) @(negedge clk);
        chk({tag, " idle after rsp"}, {cmd_ready, busy, rsp_valid}, 3'b100);
        chk({tag, " write count"}, wa_q.size() - wb, v.nw);
        chk({tag, " read count"}, rd_total - rb, v.nr);
        chk({tag, " stable addr/data"}, proto_err, 0);
        for (int k = 0; k < v.nw && wb + k < wa_q.size(); k++) begin
            chk($sformatf("%s wr%0d addr", tag, k), wa_q[wb + k], ea[k]);
            chk($sformatf("%s wr%0d data", tag, k), wd_q[wb + k], ed[k]);
        end
    endtask

    initial begin
        int acc, acc2, lat, h_edge, wb;
        bit found, stable;
        logic [1:0] st0;
        logic [19:0] p0;
        cmd_valid = 0; cmd_arg0 = 0; cmd_arg1 = 0; cmd_arg2 = 0; rsp_ready = 0;

        vecs[0] = '{a0:32'h1000, a1:32'h2000, a2:32'h40, bp:0, err:0, done_at:3,
                    st:2'b00, polls:3, nw:4, nr:3, lat:47};
        vecs[1] = '{a0:32'hDEADBEEF, a1:32'h12345678, a2:32'h0, bp:1, err:0, done_at:2,
                    st:2'b00, polls:2, nw:4, nr:2, lat:0};
        vecs[2] = '{a0:32'hA, a1:32'hB, a2:32'hC, bp:0, err:1, done_at:3,
                    st:2'b01, polls:0, nw:2, nr:0, lat:5};
        vecs[3] = '{a0:32'h1, a1:32'h2, a2:32'h3, bp:0, err:0, done_at:99,
                    st:2'b10, polls:4, nw:4, nr:4, lat:65};
        vecs[4] = '{a0:32'hFFFFFFFF, a1:32'h80000000, a2:32'h1, bp:1, err:0, done_at:1,
                    st:2'b00, polls:1, nw:4, nr:1, lat:0};
        vecs[5] = '{a0:32'h55, a1:32'hAA, a2:32'h5A5A, bp:0, err:0, done_at:4,
                    st:2'b00, polls:4, nw:4, nr:4, lat:65};

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("reset cmd_ready/busy/rsp_valid", {cmd_ready, busy, rsp_valid}, 3'b100);
        chk("reset status", rsp_status, 2'b00);
        chk("reset polls", rsp_polls, 0);
        chk("reset valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("reset awaddr", awaddr, 0);
        chk("reset araddr", araddr, 0);
        chk("reset wdata", wdata, 0);
        chk("prot/wstrb", {awprot, arprot, wstrb}, 10'h00F);

        for (int i = 0; i < 6; i++) run_launch($sformatf("v%0d", i), vecs[i]);

        // reset asserted while waiting for the CTRL write response
        bp_mode = 0; err_mode = 0; done_at = 3; rd_base = rd_total; wb = wa_q.size();
        send_cmd("rst_mid", 32'h1, 32'h2, 32'h3, 0, acc);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bready && (wa_q.size() - wb == 4)) begin found = 1; break; end
        end
        chk("rst_mid reached CTRL WR_B", found, 1);
        rst_n = 0;
        @(negedge clk);
        chk("rst_mid valids dropped", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("rst_mid cmd_ready/busy/rsp_valid", {cmd_ready, busy, rsp_valid}, 3'b100);
        rst_n = 1;
        run_launch("post_rst", vecs[0]);

        // response stall with a second command already waiting
        bp_mode = 0; err_mode = 0; done_at = 1; rd_base = rd_total;
        send_cmd("b2b first", 32'h11, 32'h22, 32'h33, 1, acc);
        cmd_arg0 = 32'hC0DE0000; cmd_arg1 = 32'hC0DE0001; cmd_arg2 = 32'hC0DE0002;
        wait_rsp("b2b first", acc, lat);
        chk("b2b first latency", lat, 11);
        st0 = rsp_status; p0 = rsp_polls;
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_status != st0 || rsp_polls != p0 || cmd_ready) stable = 0;
        end
        chk("b2b rsp stable in stall", stable, 1);
        chk("b2b first status", st0, 2'b00);
        chk("b2b first polls", p0, 1);
        rsp_ready = 1;
        h_edge = cyc + 1;
        rd_base = rd_total + 0;
        wb = wa_q.size();
        @(posedge clk); #1;
        rsp_ready = 0;
        acc2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin acc2 = cyc + 1; break; end
        end
        chk("b2b second accept gap", acc2 - h_edge, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
        wait_rsp("b2b second", acc2, lat);
        chk("b2b second latency", lat, 11);
        chk("b2b second status", rsp_status, 2'b00);
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        repeat (2) @(negedge clk);
        chk("b2b second arg0 captured", (wa_q.size() > wb) ? wd_q[wb] : 32'hX, 32'hC0DE0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/hls_kernel_launcher.md
# hls_kernel_launcher

AXI-Lite master sequencer that configures and launches one HLS accelerator kernel inside a role region (NORTH or SOUTH). It accepts a launch command (three 32-bit kernel arguments), writes them into the kernel's standard HLS control-register map, sets ap_start, and polls ap_done. It then returns a completion status. It sits in the static region between the host-facing command logic and the role's S_AXI_LITE_FROM_STATIC slave port.

## Interface
Parameters:
- ADDR_W, 12: AXI-Lite address width.
- POLL_GAP, 16: idle cycles between ap_done status reads; must be 1 or greater.
- TIMEOUT, 2**20: maximum poll reads before aborting; must be 1 or greater.

Ports:
- CLK_IN_250  in  1  sole clock; all logic rises on this edge.
- AXI_RESET_N  in  1  synchronous, active-low reset.
- cmd_valid  in  1  launch request.
- cmd_ready  out  1  high only in IDLE.
- cmd_arg0 / cmd_arg1 / cmd_arg2  in  32 each  kernel arguments, captured on accept.
- rsp_valid  out  1  completion available.
- rsp_ready  in  1  completion consumed.
- rsp_status  out  2  00 OK, 01 SLVERR (any bresp or rresp not equal to 00), 10 TIMEOUT.
- rsp_polls  out  20  number of status reads issued.
- busy  out  1  high in every state except IDLE.
- M_AXI_LITE_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI-Lite master.
  - Address signals are ADDR_W bits; data is 32 bits.
  - prot is constant 3'b000; wstrb is constant 4'hF.

## Operation
Register map written by the block:
- ARG0 at 0x10, ARG1 at 0x18, ARG2 at 0x20.
- CTRL at 0x00: bit0 ap_start, bit1 ap_done (clear-on-read), bit2 ap_idle.

State machine:
- IDLE: cmd_ready=1. On cmd_valid, capture the args, clear the poll counter, go to WR.
- WR: issue a write.
  - The write index selects the target: 0 → ARG0, 1 → ARG1, 2 → ARG2, 3 → CTRL with data 0x1.
  - awvalid and wvalid rise together. Each drops independently on its own handshake.
  - When both handshakes are done, go to WR_B.
- WR_B: bready=1.
  - On bvalid with bresp≠00: status=01, go to RSP.
  - On bvalid with bresp=00: if index is 3, go to RD; otherwise increment the index and go to WR.
- RD: arvalid=1, araddr=0x00. On arready, go to RD_R.
- RD_R: rready=1. On rvalid, increment the poll counter, then apply these in priority order:
  - rresp≠00 → status=01, go to RSP.
  - rdata[1]=1 → status=00, go to RSP.
  - poll counter = TIMEOUT → status=10, go to RSP.
  - otherwise → go to GAP.
- GAP: count POLL_GAP cycles, then go to RD.
- RSP: rsp_valid=1, holding status and polls stable. On rsp_ready, go to IDLE.

Rules:
- Only one AXI transaction is outstanding at a time.
- Address and data are stable while their valid is high.
- Valids never drop before their ready.
- No command is accepted while busy.
- rsp_polls saturates at 2**20−1.

## Timing
- Reset values:
  - State IDLE.
  - All valids, bready and rready at 0.
  - cmd_ready=1, busy=0, rsp_valid=0, rsp_status=00, rsp_polls=0.
  - awaddr, araddr and wdata at 0.
- Reset has priority over every state. Asserting it mid-transaction drops all valids on the next edge with no completion. Slave cleanup is the owner's problem.
- Command accepted at edge N → awvalid/wvalid high from cycle N+1.
- With zero-wait slaves, each write costs 2 cycles (WR, WR_B), so the 4 writes take 8 cycles.
  - Each poll costs 2 cycles plus POLL_GAP gap cycles.
- If awready and wready arrive in different cycles, the block waits for the later one. Arriving in the same cycle is legal.
- bvalid arriving in the same cycle as the last W handshake is not observed until WR_B; the slave must hold it (AXI rule).
- rsp_valid rises the cycle after the terminating B or R handshake.
  - If rsp_ready is already high, IDLE is reached the next cycle.
  - cmd_ready returns one cycle after the rsp handshake.

## Test plan
- Nominal launch:
  - Stimulus: args 0x1000/0x2000/0x40; zero-wait slave; ap_done set on the 3rd read; POLL_GAP=16.
  - Expect: writes in order 0x10, 0x18, 0x20, 0x00=0x1; rsp_status=00; rsp_polls=3; rsp_valid 8+2·3+2·16+1 cycles after accept.
- Backpressure:
  - Stimulus: random awready/wready/arready/bvalid/rvalid delays of 0–7 cycles, with awready and wready skewed.
  - Expect: no address/data change while valid is high; same write sequence; status=00.
- Slave error:
  - Stimulus: bresp=2'b10 on the ARG1 write.
  - Expect: no further AXI traffic; rsp_status=01; rsp_polls=0.
- Timeout:
  - Stimulus: TIMEOUT=4; rdata[1] never set.
  - Expect: exactly 4 reads; rsp_status=10; rsp_polls=4.
- Reset mid-operation:
  - Stimulus: drop AXI_RESET_N during WR_B of the CTRL write.
  - Expect: next edge shows all valids 0 and cmd_ready=1; a new command then runs nominally.
- Back-to-back with response stall:
  - Stimulus: rsp_ready held low for 10 cycles; cmd_valid held high.
  - Expect: rsp fields stable for the whole stall; second command accepted exactly one cycle after the rsp handshake.
